mem_port_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for the single MAR/MDR/MEM port. Shares it among

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter and sequencer for the single MAR/MDR/MEM port. It shares the
//   port among NREQ requesters: instruction fetch (0), load/store FSM (1), spare (2+).
//   The arbiter latches the winner's address, write data and direction, and drives one
//   memory access. It then waits for MFC, or aborts after TIMEOUT_CYC cycles, and
//   returns read data with a one-cycle done pulse.
//
//   Ports
//     clk, reset          rising-edge clock, synchronous active-high reset
//     req[NREQ]           level request per requester, held until its done pulse
//     req_rw[NREQ]        per-requester direction (1=read, 0=write)
//     req_addr/req_wdata  per-requester address / write data, slot i = [i*DW +: DW]
//     gnt[NREQ]           one-hot grant, high from ACCESS entry through the DONE cycle
//     done[NREQ]          one-cycle completion pulse to the granted requester
//     err                 pulses with done when the access timed out
//     rdata               read data captured on MFC, held until the next capture
//     mem_addr/mem_wdata  latched address / write data to MAR / MDR
//     mem_rw, mem_en      latched direction and enable to MEM (enable only in ACCESS)
//     mem_mfc, mem_rdata  memory-function-complete and read data from MEM
module mem_port_arbiter #(
  parameter int NREQ        = 2,
  parameter int DW          = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [NREQ*DW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [DW-1:0]     rdata,
  output logic [DW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              mem_rw,
  output logic              mem_en,
  input  logic              mem_mfc,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [7:0]      cnt;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;

  // First set request bit searching upward from the slot after the last winner, with
  // wrap-around. The last winner itself is visited last, giving round-robin fairness.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r,
                                          input logic [IW-1:0]   p);
    logic          found;
    logic [IW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(p) + i) % NREQ;
      if (!found && r[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    return {found, idx};
  endfunction

  assign {pick_vld, pick_idx} = rr_pick(req, ptr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= IW'(NREQ - 1);
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          err  <= 1'b0;
          if (pick_vld) begin
            ptr       <= pick_idx;
            gnt       <= NREQ'(1) << pick_idx;
            mem_addr  <= req_addr[int'(pick_idx)*DW +: DW];
            mem_wdata <= req_wdata[int'(pick_idx)*DW +: DW];
            mem_rw    <= req_rw[pick_idx];
            cnt       <= '0;
            mem_en    <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // MFC takes priority over a timeout that expires in the same cycle.
          if (mem_mfc) begin
            if (mem_rw) rdata <= mem_rdata;
            done   <= gnt;
            mem_en <= 1'b0;
            state  <= DONE;
          end else if (cnt == CNT_LAST) begin
            done   <= gnt;
            err    <= 1'b1;
            mem_en <= 1'b0;
            state  <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          // gnt stays up through the done pulse; request lines are re-sampled in IDLE.
          done  <= '0;
          err   <= 1'b0;
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Scoreboard bench for mem_port_arbiter (NREQ=2, DW=16, TIMEOUT_CYC=15). Expected
//   completions are queued when a request is driven and compared when done pulses.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  req_rw;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        err;
  logic [15:0] rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rw;
  logic        mem_en;
  logic        mem_mfc;
  logic [15:0] mem_rdata;

  mem_port_arbiter #(.NREQ(2), .DW(16), .TIMEOUT_CYC(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rw    (mem_rw),
    .mem_en    (mem_en),
    .mem_mfc   (mem_mfc),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  done;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_rdata = 16'h0000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic rw, input logic [15:0] addr,
                          input logic [15:0] wdata);
    req_rw[i]             = rw;
    req_addr[i*16 +: 16]  = addr;
    req_wdata[i*16 +: 16] = wdata;
  endtask

  // delay: cycles from mem_en rising to the edge that samples MFC; 0 = MFC never comes.
  task automatic run_access(input logic [1:0] reqv, input int idx, input int delay,
                            input logic [15:0] rd_val, input bit drop);
    exp_t       e;
    int         w;
    int         c;
    int         en_cnt;
    bit         got;
    logic [1:0] onehot;
    onehot = 2'b01 << idx;
    if (delay != 0 && req_rw[idx]) model_rdata = rd_val;
    e.done  = onehot;
    e.err   = (delay == 0);
    e.rdata = model_rdata;
    sbq.push_back(e);
    req = reqv;
    w = 0;
    while (w < 10) begin
      @(negedge clk);
      w++;
      if (mem_en) break;
    end
    check_val("grant_latency", w, 1);
    check_val("gnt", gnt, onehot);
    check_val("mem_addr", mem_addr, req_addr[idx*16 +: 16]);
    check_val("mem_rw", mem_rw, req_rw[idx]);
    if (!req_rw[idx]) check_val("mem_wdata", mem_wdata, req_wdata[idx*16 +: 16]);
    c = 0; en_cnt = 0; got = 0;
    while (c < 40) begin
      if (done != 2'b00) begin
        got = 1;
        break;
      end
      if (mem_en) en_cnt++;
      mem_mfc   = (delay != 0 && c == delay - 1);
      mem_rdata = mem_mfc ? rd_val : ~rd_val;
      @(negedge clk);
      c++;
    end
    mem_mfc = 1'b0;
    check_val("done_seen", got, 1);
    e = sbq.pop_front();
    if (got) begin
      check_val("done_vec", done, e.done);
      check_val("err", err, e.err);
      check_val("rdata", rdata, e.rdata);
      check_val("gnt_in_done", gnt, onehot);
      check_val("en_in_done", mem_en, 0);
    end
    check_val("en_cycles", en_cnt, (delay == 0) ? 15 : delay);
    if (drop) req = 2'b00;
    @(negedge clk);
    check_val("done_pulse_end", done, 0);
    check_val("err_pulse_end", err, 0);
    check_val("gnt_released", gnt, 0);
    check_val("en_idle", mem_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    mem_mfc = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_val("rst_gnt", gnt, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    check_val("rst_en", mem_en, 0);
    check_val("rst_rw", mem_rw, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_wdata", mem_wdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single read from requester 0, MFC two cycles after enable.
    set_slot(0, 1'b1, 16'h0010, 16'h0000);
    run_access(2'b01, 0, 2, 16'hBEEF, 1);

    // Single write from requester 1; rdata must keep 0xBEEF.
    set_slot(1, 1'b0, 16'h0020, 16'h1234);
    run_access(2'b10, 1, 1, 16'hAAAA, 1);

    // Both requesting after reset: grants alternate 0,1,0,1 with 1-cycle IDLE gaps.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_rdata = 16'h0000;
    set_slot(0, 1'b1, 16'h0100, 16'h0000);
    set_slot(1, 1'b0, 16'h0200, 16'h5555);
    run_access(2'b11, 0, 1, 16'h1111, 0);
    run_access(2'b11, 1, 3, 16'h9999, 0);
    run_access(2'b11, 0, 2, 16'h2222, 0);
    run_access(2'b11, 1, 1, 16'h8888, 1);

    // Timeout: no MFC at all.
    set_slot(0, 1'b1, 16'h0300, 16'h0000);
    run_access(2'b01, 0, 0, 16'h7777, 1);

    // MFC on the very cycle the timeout would fire: MFC wins.
    run_access(2'b01, 0, 15, 16'hC0DE, 1);

    // MFC while idle is ignored.
    mem_mfc = 1'b1; mem_rdata = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("idle_mfc_en", mem_en, 0);
      check_val("idle_mfc_done", done, 0);
      check_val("idle_mfc_gnt", gnt, 0);
    end
    mem_mfc = 1'b0;
    check_val("idle_mfc_rdata", rdata, model_rdata);

    // Reset two cycles into an access.
    set_slot(0, 1'b1, 16'h0400, 16'h0000);
    req = 2'b01;
    begin
      int w;
      w = 0;
      while (w < 10) begin
        @(negedge clk);
        w++;
        if (mem_en) break;
      end
      check_val("abort_en_seen", mem_en, 1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req   = 2'b00;
    @(negedge clk);
    check_val("abort_gnt", gnt, 0);
    check_val("abort_en", mem_en, 0);
    check_val("abort_done", done, 0);
    check_val("abort_err", err, 0);
    check_val("abort_rdata", rdata, 0);
    check_val("abort_addr", mem_addr, 0);
    reset = 1'b0;
    model_rdata = 16'h0000;
    @(negedge clk);
    check_val("post_abort_done", done, 0);
    check_val("post_abort_en", mem_en, 0);
    run_access(2'b11, 0, 2, 16'h3333, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
